cronometro_bcd: RTL and testbench

//  Countdown timer core; it drives the packed-BCD HH/MM/SS bytes that the VGA timer-digit renderer displays.
//  - Loads a user value, counts down once per second, and raises done at 00:00:00.
//  - Presents a frame-stable snapshot so digits never change mid-frame.

---
 rtl/crono_pkg.sv | 30 +++
 rtl/bcd_byte_dec.sv | 38 +++
 rtl/cronometro_bcd.sv | 195 +++++++++++++++++++
 tb/tb_cronometro_bcd.sv | 258 +++++++++++++++++++++++++
 4 files changed

// File: rtl/crono_pkg.sv
// Shared types and constants for the cronometro_bcd countdown timer:
// FSM state encoding, packed-BCD time record and the load-validation helper.
package crono_pkg;

    localparam int BCD_W = 8;

    localparam logic [BCD_W-1:0] SEC_MAX = 8'h59;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        PAUSE = 2'd2,
        DONE  = 2'd3
    } crono_state_t;

    typedef struct packed {
        logic [BCD_W-1:0] hh;
        logic [BCD_W-1:0] mm;
        logic [BCD_W-1:0] ss;
    } bcd_time_t;

    localparam bcd_time_t ZERO_TIME = '{hh: 8'h00, mm: 8'h00, ss: 8'h00};

    // Nibble-wise compare is valid once both nibbles are known to be decimal digits
    function automatic logic bcd_byte_ok(input logic [BCD_W-1:0] b,
                                         input logic [BCD_W-1:0] max_b);
        return (b[7:4] <= 4'd9) && (b[3:0] <= 4'd9) && (b <= max_b);
    endfunction

endpackage

// File: rtl/bcd_byte_dec.sv
// One stage of the packed-BCD borrow chain: decrements a {tens,units} byte
// when borrow_in is set, wrapping tens to tens_max and signalling borrow_out.
module bcd_byte_dec
    import crono_pkg::*;
(
    input  logic [BCD_W-1:0] byte_in,
    input  logic [3:0]       tens_max,
    input  logic             borrow_in,
    output logic [BCD_W-1:0] byte_out,
    output logic             borrow_out
);

    logic [3:0] tens_s;
    logic [3:0] units_s;

    assign tens_s  = byte_in[7:4];
    assign units_s = byte_in[3:0];

    // Borrow-chain decrement of a single packed-BCD byte
    always_comb begin
        byte_out   = byte_in;
        borrow_out = 1'b0;
        if (!borrow_in) begin
            byte_out   = byte_in;
            borrow_out = 1'b0;
        end else if (units_s != 4'd0) begin
            byte_out   = {tens_s, units_s - 4'd1};
            borrow_out = 1'b0;
        end else if (tens_s != 4'd0) begin
            byte_out   = {tens_s - 4'd1, 4'd9};
            borrow_out = 1'b0;
        end else begin
            byte_out   = {tens_max, 4'd9};
            borrow_out = 1'b1;
        end
    end

endmodule

// File: rtl/cronometro_bcd.sv
// HH:MM:SS packed-BCD countdown timer with a display snapshot register.
// Define CRONO_FRAME_SYNC_EN to refresh timer_out* only after a synchronised vblank rise.
module cronometro_bcd
    import crono_pkg::*;
#(
    parameter int               CLK_HZ = 100_000_000,
    parameter logic [BCD_W-1:0] HH_MAX = 8'h23
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             load,
    input  logic             start,
    input  logic             stop,
    input  logic [BCD_W-1:0] hh_in,
    input  logic [BCD_W-1:0] mm_in,
    input  logic [BCD_W-1:0] ss_in,
    input  logic             vblank,
    output logic [BCD_W-1:0] timer_out1,
    output logic [BCD_W-1:0] timer_out2,
    output logic [BCD_W-1:0] timer_out3,
    output logic             running,
    output logic             done,
    output logic             load_err
);

    localparam int              PS_W   = (CLK_HZ > 1) ? $clog2(CLK_HZ) : 1;
    localparam logic [PS_W-1:0] PS_TC  = PS_W'(CLK_HZ - 1);
    localparam logic [PS_W-1:0] PS_ONE = PS_W'(1);

    crono_state_t    state_r;
    bcd_time_t       cnt_r;
    bcd_time_t       snap_r;
    logic [PS_W-1:0] ps_r;
    logic            running_r;
    logic            done_r;
    logic            load_err_r;

    bcd_time_t       dec_s;
    logic            ss_borrow_s;
    logic            mm_borrow_s;
    logic            cnt_zero_s;
    logic            dec_zero_s;
    logic            load_ok_s;
    logic            ps_wrap_s;

    // The chain always decrements; borrowing out of the hours byte means the count is 00:00:00
    bcd_byte_dec u_dec_ss (
        .byte_in    (cnt_r.ss),
        .tens_max   (SEC_MAX[7:4]),
        .borrow_in  (1'b1),
        .byte_out   (dec_s.ss),
        .borrow_out (ss_borrow_s)
    );

    bcd_byte_dec u_dec_mm (
        .byte_in    (cnt_r.mm),
        .tens_max   (SEC_MAX[7:4]),
        .borrow_in  (ss_borrow_s),
        .byte_out   (dec_s.mm),
        .borrow_out (mm_borrow_s)
    );

    bcd_byte_dec u_dec_hh (
        .byte_in    (cnt_r.hh),
        .tens_max   (HH_MAX[7:4]),
        .borrow_in  (mm_borrow_s),
        .byte_out   (dec_s.hh),
        .borrow_out (cnt_zero_s)
    );

    // Load validation, terminal-count and zero detection
    always_comb begin
        load_ok_s  = bcd_byte_ok(hh_in, HH_MAX)
                  && bcd_byte_ok(mm_in, SEC_MAX)
                  && bcd_byte_ok(ss_in, SEC_MAX);
        ps_wrap_s  = (ps_r == PS_TC);
        dec_zero_s = (dec_s == ZERO_TIME);
    end

    // Control FSM, prescaler and counter; a load (even a rejected one) owns the cycle
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_r    <= IDLE;
            cnt_r      <= ZERO_TIME;
            ps_r       <= '0;
            running_r  <= 1'b0;
            done_r     <= 1'b0;
            load_err_r <= 1'b0;
        end else begin
            load_err_r <= 1'b0;
            if (load) begin
                if (load_ok_s) begin
                    cnt_r     <= '{hh: hh_in, mm: mm_in, ss: ss_in};
                    ps_r      <= '0;
                    done_r    <= 1'b0;
                    state_r   <= IDLE;
                    running_r <= 1'b0;
                end else begin
                    load_err_r <= 1'b1;
                end
            end else begin
                case (state_r)
                    IDLE: begin
                        if (start && !cnt_zero_s) begin
                            state_r   <= RUN;
                            running_r <= 1'b1;
                        end
                    end
                    RUN: begin
                        if (stop) begin
                            // A tick due on the stop edge is deferred to the first cycle after resume
                            state_r   <= PAUSE;
                            running_r <= 1'b0;
                            if (!ps_wrap_s) begin
                                ps_r <= ps_r + PS_ONE;
                            end
                        end else if (ps_wrap_s) begin
                            ps_r <= '0;
                            if (!cnt_zero_s) begin
                                cnt_r <= dec_s;
                            end
                            if (dec_zero_s || cnt_zero_s) begin
                                state_r   <= DONE;
                                running_r <= 1'b0;
                                done_r    <= 1'b1;
                            end
                        end else begin
                            ps_r <= ps_r + PS_ONE;
                        end
                    end
                    PAUSE: begin
                        if (start) begin
                            state_r   <= RUN;
                            running_r <= 1'b1;
                        end
                    end
                    DONE: begin
                        state_r <= DONE;
                    end
                    default: begin
                        state_r   <= IDLE;
                        running_r <= 1'b0;
                    end
                endcase
            end
        end
    end

`ifdef CRONO_FRAME_SYNC_EN
    logic vb_meta_r;
    logic vb_sync_r;
    logic vb_prev_r;
    logic vb_rise_s;

    assign vb_rise_s = vb_sync_r & ~vb_prev_r;

    // Synchronise vblank and refresh the snapshot once per frame
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            vb_meta_r <= 1'b0;
            vb_sync_r <= 1'b0;
            vb_prev_r <= 1'b0;
            snap_r    <= ZERO_TIME;
        end else begin
            vb_meta_r <= vblank;
            vb_sync_r <= vb_meta_r;
            vb_prev_r <= vb_sync_r;
            if (vb_rise_s) begin
                snap_r <= cnt_r;
            end
        end
    end
`else
    logic vblank_unused_s;

    assign vblank_unused_s = vblank;

    // Snapshot simply trails the counter by one cycle
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            snap_r <= ZERO_TIME;
        end else begin
            snap_r <= cnt_r;
        end
    end
`endif

    assign timer_out1 = snap_r.hh;
    assign timer_out2 = snap_r.mm;
    assign timer_out3 = snap_r.ss;
    assign running    = running_r;
    assign done       = done_r;
    assign load_err   = load_err_r;

endmodule

// File: tb/tb_cronometro_bcd.sv
// Scoreboard bench for cronometro_bcd: a seconds-count reference model predicts every
// output cycle, a negedge monitor compares; directed scenarios plus random stimulus.
module tb_cronometro_bcd;

    localparam int CLK_HZ = 4;
    localparam int M_IDLE = 0;
    localparam int M_RUN = 1;
    localparam int M_PAUSE = 2;
    localparam int M_DONE = 3;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic       load = 1'b0;
    logic       start = 1'b0;
    logic       stop = 1'b0;
    logic       vblank = 1'b0;
    logic [7:0] hh_in = 8'h00;
    logic [7:0] mm_in = 8'h00;
    logic [7:0] ss_in = 8'h00;
    logic [7:0] timer_out1;
    logic [7:0] timer_out2;
    logic [7:0] timer_out3;
    logic       running;
    logic       done;
    logic       load_err;

    cronometro_bcd #(.CLK_HZ(CLK_HZ), .HH_MAX(8'h23)) dut (
        .clk        (clk),
        .reset      (reset),
        .load       (load),
        .start      (start),
        .stop       (stop),
        .hh_in      (hh_in),
        .mm_in      (mm_in),
        .ss_in      (ss_in),
        .vblank     (vblank),
        .timer_out1 (timer_out1),
        .timer_out2 (timer_out2),
        .timer_out3 (timer_out3),
        .running    (running),
        .done       (done),
        .load_err   (load_err)
    );

    always #5 clk = ~clk;

    int          checks = 0;
    int          failures = 0;
    logic [26:0] exp_q[$];
    bit          mon_en = 1'b0;
    logic [26:0] mon_exp;
    logic [26:0] mon_act;

    // Reference model: remaining time as plain seconds
    int m_secs, m_phase, m_mode, m_disp;
    bit m_done, m_err, m_run, m_vb1, m_vb2, m_vb3;

    function automatic int from_bcd(input logic [7:0] b);
        return int'(b[7:4]) * 10 + int'(b[3:0]);
    endfunction

    function automatic logic [7:0] to_bcd(input int v);
        return 8'((v / 10) * 16 + (v % 10));
    endfunction

    function automatic logic [23:0] secs_to_bcd(input int s);
        return {to_bcd(s / 3600), to_bcd((s / 60) % 60), to_bcd(s % 60)};
    endfunction

    function automatic bit bcd_ok(input logic [7:0] b, input int maxv);
        return (b[7:4] <= 4'd9) && (b[3:0] <= 4'd9) && (from_bcd(b) <= maxv);
    endfunction

    task automatic model_reset();
        m_secs = 0; m_phase = 0; m_mode = M_IDLE; m_disp = 0;
        m_done = 1'b0; m_err = 1'b0; m_run = 1'b0;
        m_vb1 = 1'b0; m_vb2 = 1'b0; m_vb3 = 1'b0;
    endtask

    task automatic model_step(input bit ld, input bit st, input bit sp, input bit vb,
                              input logic [7:0] h, input logic [7:0] m, input logic [7:0] s);
        int cnt_old;
        bit rise;
        cnt_old = m_secs;
        rise = m_vb2 && !m_vb3;
        m_err = 1'b0;
        if (ld) begin
            if (bcd_ok(h, 23) && bcd_ok(m, 59) && bcd_ok(s, 59)) begin
                m_secs = from_bcd(h) * 3600 + from_bcd(m) * 60 + from_bcd(s);
                m_phase = 0; m_done = 1'b0; m_mode = M_IDLE;
            end else begin
                m_err = 1'b1;
            end
        end else if (sp && m_mode == M_RUN) begin
            m_mode = M_PAUSE;
            if (m_phase < CLK_HZ - 1) m_phase++;
        end else if (st && ((m_mode == M_IDLE && m_secs != 0) || m_mode == M_PAUSE)) begin
            m_mode = M_RUN;
        end else if (m_mode == M_RUN) begin
            if (m_phase == CLK_HZ - 1) begin
                m_phase = 0;
                m_secs--;
                if (m_secs == 0) begin
                    m_mode = M_DONE;
                    m_done = 1'b1;
                end
            end else begin
                m_phase++;
            end
        end
`ifdef CRONO_FRAME_SYNC_EN
        if (rise) m_disp = cnt_old;
        m_vb3 = m_vb2; m_vb2 = m_vb1; m_vb1 = vb;
`else
        m_disp = cnt_old;
`endif
        m_run = (m_mode == M_RUN);
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=%h required=%h", name, act, req);
        end
    endtask

    task automatic step(input bit ld, input bit st, input bit sp, input bit vb,
                        input logic [7:0] h, input logic [7:0] m, input logic [7:0] s);
        load = ld; start = st; stop = sp; vblank = vb;
        hh_in = h; mm_in = m; ss_in = s;
        model_step(ld, st, sp, vb, h, m, s);
        @(posedge clk);
        #1;
        exp_q.push_back({secs_to_bcd(m_disp), m_run, m_done, m_err});
        load = 1'b0; start = 1'b0; stop = 1'b0;
    endtask

    task automatic idle();
        step(1'b0, 1'b0, 1'b0, vblank, 8'h00, 8'h00, 8'h00);
    endtask

    // Monitor: one predicted output vector per cycle
    always @(negedge clk) begin
        if (mon_en && exp_q.size() > 0) begin
            mon_exp = exp_q.pop_front();
            mon_act = {timer_out1, timer_out2, timer_out3, running, done, load_err};
            checks++;
            if (mon_act !== mon_exp) begin
                failures++;
                $display("FAIL out t=%0t actual=%h required=%h", $time, mon_act, mon_exp);
            end
        end
    end

    initial begin
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        chk("reset_outs", 32'({timer_out1, timer_out2, timer_out3, running, done, load_err}), 32'd0);
        reset = 1'b1;
        mon_en = 1'b1;

        // 00:00:03 counts to zero in 12 clocks
        step(1'b1, 1'b0, 1'b0, 1'b0, 8'h00, 8'h00, 8'h03);
        step(1'b0, 1'b1, 1'b0, 1'b0, 8'h00, 8'h00, 8'h00);
        chk("t1_running", 32'(running), 32'd1);
        for (int i = 1; i <= 13; i++) begin
            idle();
`ifndef CRONO_FRAME_SYNC_EN
            if (i == 5) chk("t1_disp2", 32'({timer_out1, timer_out2, timer_out3}), 32'h000002);
            if (i == 9) chk("t1_disp1", 32'({timer_out1, timer_out2, timer_out3}), 32'h000001);
            if (i == 13) chk("t1_disp0", 32'({timer_out1, timer_out2, timer_out3}), 32'h000000);
`endif
            if (i == 11) chk("t1_done_early", 32'(done), 32'd0);
            if (i == 12) chk("t1_done", 32'({done, running}), 32'b10);
        end

        // 01:00:00 borrows through all bytes
        step(1'b1, 1'b0, 1'b0, 1'b0, 8'h01, 8'h00, 8'h00);
        chk("t2_done_clr", 32'(done), 32'd0);
        step(1'b0, 1'b1, 1'b0, 1'b0, 8'h00, 8'h00, 8'h00);
        repeat (5) idle();
`ifndef CRONO_FRAME_SYNC_EN
        chk("t2_borrow", 32'({timer_out1, timer_out2, timer_out3}), 32'h005959);
`endif
        step(1'b0, 1'b0, 1'b1, 1'b0, 8'h00, 8'h00, 8'h00);

        // Rejected load: minutes out of range
        step(1'b1, 1'b0, 1'b0, 1'b0, 8'h00, 8'h60, 8'h00);
        chk("t3_err", 32'(load_err), 32'd1);
        idle();
        chk("t3_err_pulse", 32'({load_err, running}), 32'd0);
`ifndef CRONO_FRAME_SYNC_EN
        chk("t3_cnt_kept", 32'({timer_out1, timer_out2, timer_out3}), 32'h005959);
`endif

        // Pause keeps prescaler phase
        step(1'b1, 1'b0, 1'b0, 1'b0, 8'h00, 8'h00, 8'h05);
        step(1'b0, 1'b1, 1'b0, 1'b0, 8'h00, 8'h00, 8'h00);
        idle();
        step(1'b0, 1'b0, 1'b1, 1'b0, 8'h00, 8'h00, 8'h00);
        repeat (10) idle();
        step(1'b0, 1'b1, 1'b0, 1'b0, 8'h00, 8'h00, 8'h00);
        idle();
        idle();
`ifndef CRONO_FRAME_SYNC_EN
        chk("t4_not_yet", 32'(timer_out3), 32'h05);
        idle();
        chk("t4_resume", 32'(timer_out3), 32'h04);
`endif

        // Asynchronous reset mid-run
        step(1'b1, 1'b0, 1'b0, 1'b0, 8'h00, 8'h05, 8'h00);
        step(1'b0, 1'b1, 1'b0, 1'b0, 8'h00, 8'h00, 8'h00);
        repeat (7) idle();
        @(negedge clk);
        #1;
        mon_en = 1'b0;
        reset = 1'b0;
        #1;
        chk("t6_async_rst", 32'({timer_out1, timer_out2, timer_out3, running, done, load_err}), 32'd0);
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b1;
        model_reset();
        exp_q.delete();
        mon_en = 1'b1;
        step(1'b0, 1'b1, 1'b0, 1'b0, 8'h00, 8'h00, 8'h00);
        chk("t6_start_zero", 32'(running), 32'd0);

        // Random traffic, including coincident events and invalid loads
        for (int n = 0; n < 800; n++) begin
            bit         ld, st, sp, vb;
            logic [7:0] h, m, s;
            ld = ($urandom_range(0, 29) == 0);
            st = ($urandom_range(0, 7) == 0);
            sp = ($urandom_range(0, 15) == 0);
            vb = ($urandom_range(0, 9) == 0) ? ~vblank : vblank;
            if ($urandom_range(0, 3) == 0) begin
                h = 8'($urandom); m = 8'($urandom); s = 8'($urandom);
            end else begin
                h = to_bcd(int'($urandom_range(0, 1)));
                m = to_bcd(int'($urandom_range(0, 1)));
                s = to_bcd(int'($urandom_range(0, 12)));
            end
            step(ld, st, sp, vb, h, m, s);
        end

        repeat (3) idle();
        @(negedge clk);
        #1;
        chk("drain", 32'(exp_q.size()), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
